// File: rtl/sel4_arbiter_pkg.sv
// Shared types and constants for the 4:1 selector arbiter (package sel4_pkg).
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
//
// Contents: FSM state enum, requester index type, index -> {S6,S2} select
// encoding table, and counter widths (3-bit settle, 4-bit hold).
package sel4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef logic [1:0] req_idx_t;

  localparam int SETTLE_W = 3;
  localparam int HOLD_W   = 4;

  // {S6,S2} per requester. Element [n] is the code for requester n:
  // 0 -> 11 (A1), 1 -> 10 (A2), 2 -> 00 (B1), 3 -> 01 (B2).
  // The cell's mapping is not a binary count, so a table rather than arithmetic.
  localparam logic [3:0][1:0] SEL_ENC = {2'b01, 2'b00, 2'b10, 2'b11};

  function automatic logic [1:0] sel_code(input req_idx_t idx);
    return SEL_ENC[idx];
  endfunction

endpackage

// File: rtl/sel4_arbiter_if.sv
// Requester/selector side bundle of the 4:1 selector arbiter.
// Latency: n/a (wires only).
// Backpressure: level request held until grant observed; no other flow control.
//
// Signals: req[3:0] (requester -> arbiter), grant[3:0] one-hot,
// sel_s2/sel_s6 selector terminals, sel_valid, busy (arbiter -> users).
// Modports: master = requester/user side, slave = arbiter side.
interface sel4_arbiter_if;

  logic [3:0] req;
  logic [3:0] grant;
  logic       sel_s2;
  logic       sel_s6;
  logic       sel_valid;
  logic       busy;

  modport master (
    output req,
    input  grant,
    input  sel_s2,
    input  sel_s6,
    input  sel_valid,
    input  busy
  );

  modport slave (
    input  req,
    output grant,
    output sel_s2,
    output sel_s6,
    output sel_valid,
    output busy
  );

endinterface

// File: rtl/sel4_arbiter_rr_pick.sv
// Rotate-priority picker (module sel4_rr_pick): first asserted req scanning last+1, last+2, ... mod 4.
// Latency: combinational, zero cycles.
// Backpressure: none; found=0 when no request is asserted.
//
// Ports: req[3:0] in, last (index granted most recently) in,
//        found out, index out (valid only when found=1).
module sel4_rr_pick
  import sel4_pkg::*;
(
  input  logic [3:0] req,
  input  req_idx_t   last,
  output logic       found,
  output req_idx_t   index
);

  req_idx_t cand;

  always_comb begin
    found = 1'b0;
    index = last;
    cand  = last;
    // Offsets 1..4 so that the most recently served index is checked last.
    for (int i = 1; i <= 4; i++) begin
      cand = last + req_idx_t'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/sel4_arbiter.sv
// Round-robin arbiter sharing one 4:1 selector cell among four requesters; drives S2/S6 and sel_valid.
// Latency: grant 1 cycle after req; sel_valid 1+SETTLE_CYCLES cycles after req; tenure <= HOLD_CYCLES valid cycles.
// Backpressure: requests are level-held until granted; a dropped granted req ends the tenure at the next edge.
//
// Ports: clk, reset (synchronous, active-high), bus (sel4_arbiter_if.slave):
//   req[3:0] in, grant[3:0] out (one-hot, registered), sel_s2/sel_s6 out,
//   sel_valid out (state ACTIVE), busy out (state != IDLE).
// Build option: define SEL4_FIXED_PRIO_EN for fixed priority (0 highest);
// otherwise round-robin. Timing is the same either way.
module sel4_arbiter
  import sel4_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,  // 1..7
  parameter int HOLD_CYCLES   = 4   // 1..15
) (
  input  logic           clk,
  input  logic           reset,
  sel4_arbiter_if.slave  bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_LD   = HOLD_W'(HOLD_CYCLES);

  state_t                state_q, state_d;
  logic [3:0]            grant_q, grant_d;
  logic                  s2_q, s2_d;
  logic                  s6_q, s6_d;
  req_idx_t              last_q, last_d;
  req_idx_t              cur_q, cur_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;

  req_idx_t              pick_last;
  logic                  pick_found;
  req_idx_t              pick_idx;

`ifdef SEL4_FIXED_PRIO_EN
  // Scanning from 3+1 wraps to 0 first, giving 0 > 1 > 2 > 3.
  assign pick_last = 2'd3;
`else
  assign pick_last = last_q;
`endif

  sel4_rr_pick u_pick (
    .req   (bus.req),
    .last  (pick_last),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      s2_q     <= 1'b1;
      s6_q     <= 1'b1;
      last_q   <= 2'd3;
      cur_q    <= 2'd0;
      settle_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      s2_q     <= s2_d;
      s6_q     <= s6_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      settle_q <= settle_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    s2_d     = s2_q;
    s6_d     = s6_q;
    last_d   = last_q;
    cur_d    = cur_q;
    settle_d = settle_q;
    hold_d   = hold_q;

    case (state_q)
      IDLE: begin
        // Select terminals move only here, so the path is stable for the whole tenure.
        if (pick_found) begin
          state_d      = SETTLE;
          cur_d        = pick_idx;
          grant_d      = 4'b0001 << pick_idx;
          {s6_d, s2_d} = sel_code(pick_idx);
          settle_d     = SETTLE_LD;
        end
      end

      SETTLE: begin
        if (!bus.req[cur_q]) begin
          // Requester gave up before data was usable: abort, still counts as its turn.
          state_d  = IDLE;
          grant_d  = 4'b0000;
          last_d   = cur_q;
          settle_d = '0;
        end else if (settle_q <= SETTLE_W'(1)) begin
          state_d  = ACTIVE;
          hold_d   = HOLD_LD;
          settle_d = '0;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end

      ACTIVE: begin
        if (!bus.req[cur_q] || hold_q == HOLD_W'(1)) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          last_d  = cur_q;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.sel_s2    = s2_q;
  assign bus.sel_s6    = s6_q;
  assign bus.sel_valid = (state_q == ACTIVE);
  assign bus.busy      = (state_q != IDLE);

endmodule
